// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce/auto-repeat input conditioner.
// Counter widths are derived from the channel parameters with the helpers below.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_N_CH          = 3;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;

  // Bits needed to hold the values 0..max_count, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 32'd1) ? 32'd1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DEF_STABLE_W = cnt_width(DEF_STABLE_CYCLES);
  localparam int unsigned DEF_RPT_W    = cnt_width(max2(DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD));

endpackage

// File: rtl/debounce_repeat_ch.sv
// One input channel: synchroniser, counter-based debouncer, registered
// press/release pulses and an auto-repeat FSM for held buttons.
module debounce_repeat_ch
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned DB_W  = cnt_width(STABLE_CYCLES);
  localparam int unsigned RPT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;

  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             rise_w, fall_w;

  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_pulse_w;

  logic             press_q, release_q;

  // NOTE: every clocked register uses non-blocking assignment so that all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise_w   = 1'b0;
    fall_w   = 1'b0;
    if (sync_w == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
      rise_w   = ~level_q;
      fall_w   = level_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // A falling level always wins, which keeps press and release mutually exclusive.
  always_comb begin
    state_d     = state_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_pulse_w = 1'b0;
    if (fall_w) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_w) begin
            state_d   = HOLD;
            rpt_cnt_d = '0;
          end
        end
        HOLD: begin
          if (!rep_en_i) begin
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            rpt_pulse_w = 1'b1;
            rpt_cnt_d   = '0;
            state_d     = REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!rep_en_i) begin
            state_d   = HOLD;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == PERIOD_LAST) begin
            rpt_pulse_w = 1'b1;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      press_q   <= rise_w | rpt_pulse_w;
      release_q <= fall_w;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/debounce_repeat.sv
// N-channel pushbutton/switch conditioner: one independent debounce/repeat
// channel per raw input, outputs concatenated bit-per-channel.
module debounce_repeat
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in_i,
  input  logic [N_CH-1:0] rep_en_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_repeat_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (raw_in_i[g]),
      .rep_en_i (rep_en_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g])
    );
  end

endmodule

// File: tb/tb_debounce_repeat.sv
// Bench for debounce_repeat: window-based behavioural model compared every
// cycle, plus directed scenarios with hand-computed cycle distances.
module tb_debounce_repeat;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw_in, rep_en, level, press, rel;

  always #5 clk = ~clk;

  debounce_repeat #(
    .N_CH(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in_i (raw_in),
    .rep_en_i (rep_en),
    .level_o  (level),
    .press_o  (press),
    .release_o(rel)
  );

  // ---------------- behavioural model ----------------
  // Level flips once the last SC synchronised samples all disagree with it.
  // Repeats fire a fixed number of enabled edges after an anchor edge.
  int           cyc = 0;
  bit           model_ok = 1'b0;
  logic [N-1:0] pipe [SS];
  logic [N-1:0] dwin [$];
  logic [N-1:0] m_level, m_press, m_rel, held, first;
  int           anchor [N];

  always @(posedge clk) begin
    logic [N-1:0] d;
    bit           flip;
    cyc++;
    if (reset) begin
      for (int j = 0; j < SS; j++) pipe[j] = '0;
      dwin.delete();
      m_level = '0; m_press = '0; m_rel = '0; held = '0; first = '0;
      for (int i = 0; i < N; i++) anchor[i] = 0;
      model_ok = 1'b1;
    end else begin
      d = pipe[0];
      for (int j = 0; j < SS - 1; j++) pipe[j] = pipe[j+1];
      pipe[SS-1] = raw_in;
      dwin.push_back(d);
      if (dwin.size() > SC) void'(dwin.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        flip = (dwin.size() == SC);
        foreach (dwin[j]) if (dwin[j][i] == m_level[i]) flip = 1'b0;
        if (flip) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i] = 1'b1; held[i] = 1'b1; first[i] = 1'b1; anchor[i] = cyc;
          end else begin
            m_rel[i] = 1'b1; held[i] = 1'b0;
          end
        end else if (held[i]) begin
          if (!rep_en[i]) begin
            anchor[i] = cyc; first[i] = 1'b1;
          end else if (( first[i] && (cyc - anchor[i] == RD)) ||
                       (!first[i] && (cyc - anchor[i] == RP))) begin
            m_press[i] = 1'b1; anchor[i] = cyc; first[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_err = 0;
  int np [N];
  int nr [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Advance one cycle, compare every output against the model, tally pulses.
  task automatic tick();
    @(negedge clk);
    if (model_ok) begin
      check("model_level",   32'(level), 32'(m_level));
      check("model_press",   32'(press), 32'(m_press));
      check("model_release", 32'(rel),   32'(m_rel));
    end
    for (int i = 0; i < N; i++) begin
      if (press[i] === 1'b1) np[i]++;
      if (rel[i]   === 1'b1) nr[i]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_pulse(input int ch, input bit want_rel, input int budget,
                            input string name, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if ((want_rel ? rel[ch] : press[ch]) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no pulse on channel %0d within %0d cycles", name, ch, budget);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int  s, t0, t1, t2, t3, tr, last, at, base_p, base_r, hi, r;
    bit  found;
    for (int i = 0; i < N; i++) begin np[i] = 0; nr[i] = 0; end

    reset = 1'b1; raw_in = '0; rep_en = '0;
    ticks(3);
    check("reset_level",   32'(level), 0);
    check("reset_press",   32'(press), 0);
    check("reset_release", 32'(rel),   0);
    reset = 1'b0;
    ticks(2);

    // Bounce on channel 0: 2-cycle toggles never settle, final edge does.
    base_p = np[0]; base_r = nr[0];
    for (int k = 0; k < 10; k++) begin
      raw_in[0] = ~raw_in[0];
      ticks(2);
    end
    raw_in[0] = 1'b1;
    last = cyc;
    at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (level[0] === 1'b1) begin at = cyc; break; end
    end
    check("bounce_latency", 32'(at - last), 6);
    ticks(5);
    check("bounce_press_count",   32'(np[0] - base_p), 1);
    check("bounce_release_count", 32'(nr[0] - base_r), 0);
    raw_in[0] = 1'b0;
    ticks(10);

    // Glitch on channel 1: three high cycles are one short of the stable time.
    base_p = np[1]; base_r = nr[1]; hi = 0;
    raw_in[1] = 1'b1;
    ticks(3);
    raw_in[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (level[1] !== 1'b0) hi++;
    end
    check("glitch_level_high",    32'(hi), 0);
    check("glitch_press_count",   32'(np[1] - base_p), 0);
    check("glitch_release_count", 32'(nr[1] - base_r), 0);

    // Auto-repeat on channel 0, held 40 cycles.
    rep_en[0] = 1'b1;
    raw_in[0] = 1'b1;
    s = cyc;
    wait_pulse(0, 1'b0, 20, "rpt_t0", t0);
    check("rpt_t0_latency", 32'(t0 - s), 6);
    wait_pulse(0, 1'b0, 20, "rpt_first", t1);
    check("rpt_first_repeat", 32'(t1 - t0), 10);
    wait_pulse(0, 1'b0, 20, "rpt_second", t2);
    check("rpt_second_repeat", 32'(t2 - t0), 13);
    wait_pulse(0, 1'b0, 20, "rpt_third", t3);
    check("rpt_third_repeat", 32'(t3 - t0), 16);
    base_p = np[0];
    while (cyc < s + 40) tick();
    raw_in[0] = 1'b0;
    last = cyc;
    wait_pulse(0, 1'b1, 20, "rpt_release", tr);
    check("rpt_release_latency", 32'(tr - last), 6);
    // Repeats at t0+19..t0+37; the one due on the release cycle is dropped.
    check("rpt_press_count_tail", 32'(np[0] - base_p), 7);
    base_p = np[0];
    ticks(20);
    check("rpt_press_after_release", 32'(np[0] - base_p), 0);
    rep_en[0] = 1'b0;

    // Repeat disabled on channel 2, then enabled at t0+20.
    rep_en[2] = 1'b0;
    raw_in[2] = 1'b1;
    wait_pulse(2, 1'b0, 20, "norpt_t0", t0);
    base_p = np[2];
    while (cyc < t0 + 20) tick();
    check("norpt_extra_press", 32'(np[2] - base_p), 0);
    rep_en[2] = 1'b1;
    wait_pulse(2, 1'b0, 20, "norpt_resume", t1);
    check("norpt_resume_delay", 32'(t1 - t0), 30);
    wait_pulse(2, 1'b0, 20, "norpt_next", t2);
    check("norpt_next_repeat", 32'(t2 - t0), 33);
    raw_in[2] = 1'b0;
    rep_en[2] = 1'b0;
    ticks(12);

    // Reset while channel 0 sits in REPEAT, raw still high afterwards.
    rep_en[0] = 1'b1;
    raw_in[0] = 1'b1;
    wait_pulse(0, 1'b0, 20, "rst_t0", t0);
    while (cyc < t0 + 12) tick();
    base_r = nr[0];
    reset = 1'b1;
    tick();
    check("rst_mid_level",   32'(level), 0);
    check("rst_mid_press",   32'(press), 0);
    check("rst_mid_release", 32'(rel),   0);
    tick();
    reset = 1'b0;
    r = cyc;
    wait_pulse(0, 1'b0, 20, "rst_repress", at);
    check("rst_repress_latency", 32'(at - r), 6);
    check("rst_no_release", 32'(nr[0] - base_r), 0);
    raw_in[0] = 1'b0;
    rep_en[0] = 1'b0;
    wait_pulse(0, 1'b1, 20, "rst_final_release", at);
    ticks(5);

    // Simultaneous rise and fall on all channels.
    raw_in = '1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (press !== '0) begin
        check("sim_press_all", 32'(press), 32'h7);
        tick();
        check("sim_press_width", 32'(press), 0);
        found = 1'b1;
        break;
      end
    end
    check("sim_press_seen", 32'(found), 1);
    raw_in = '0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rel !== '0) begin
        check("sim_release_all", 32'(rel), 32'h7);
        tick();
        check("sim_release_width", 32'(rel), 0);
        found = 1'b1;
        break;
      end
    end
    check("sim_release_seen", 32'(found), 1);
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/debounce_repeat.md
Name: debounce_repeat

Overview:
Parametrised N-channel input conditioner for the board pushbuttons and switches. Per channel it provides:
- a synchroniser;
- a counter-based debouncer with a configurable stable time;
- a clean debounced level;
- single-cycle press/release pulses;
- an optional auto-repeat of the press pulse while a button is held, so held up/down keys step a value continuously.

It sits between the raw board pins and the control FSMs that consume increment/decrement/select events.

Parameters:
- N_CH, 3, number of independent input channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).
- STABLE_CYCLES, 500000, consecutive cycles a synchronised input must differ from the debounced level before the level changes (>=1; 5 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- raw_in  in  N_CH  asynchronous button/switch inputs, active-high.
- rep_en  in  N_CH  per-channel auto-repeat enable, sampled every cycle.
- level  out  N_CH  debounced, registered input level.
- press  out  N_CH  one-cycle pulse on debounced rising edge and on every repeat event.
- release  out  N_CH  one-cycle pulse on debounced falling edge.

Behaviour:
- Reset (synchronous): synchroniser flops, debounce counters, repeat counters, level, press and release all go to 0; every repeat FSM goes to IDLE.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops to sync[i]. Raw channels have no other cross-channel interaction.
- Debounce counter (width $clog2(STABLE_CYCLES+1)):
  - sync==level: counter is cleared.
  - sync!=level: counter increments.
  - On the edge where the counter would reach STABLE_CYCLES, level toggles and the counter clears.
  - A disagreement shorter than STABLE_CYCLES cycles never changes level.
- Latency: a clean raw edge appears on level exactly SYNC_STAGES+STABLE_CYCLES cycles later, ±1 cycle for sampling phase.
- press[i] and release[i] are registered and asserted in the same cycle level[i] first shows its new value. They last exactly one cycle.
- Repeat FSM per channel, states IDLE / HOLD / REPEAT, with a repeat counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE→HOLD: on the press edge; repeat counter cleared.
  - HOLD: counter increments each cycle.
    - Counter reaches REPEAT_DELAY-1 with rep_en[i]=1: press pulses next cycle, counter clears, go to REPEAT. The first repeat lands at t0+REPEAT_DELAY, where t0 is the initial press cycle.
    - rep_en[i]=0: counter holds at 0 and no repeats are issued.
  - REPEAT: counter increments. On reaching REPEAT_PERIOD-1, press pulses and the counter clears. Repeats land at t0+REPEAT_DELAY+k*REPEAT_PERIOD.
  - rep_en[i] deasserted in HOLD or REPEAT: go to HOLD with counter 0. Repeats resume REPEAT_DELAY cycles after re-enable.
  - Any state→IDLE: when level falls (release cycle); repeat counter cleared.
- press and release are never asserted together on one channel, because level can change at most once per STABLE_CYCLES.
- Input high through reset: after reset deasserts, level rises after SYNC_STAGES+STABLE_CYCLES cycles with a normal press pulse.
- Reset mid-hold: all outputs 0 the cycle after reset is sampled; there are no spurious release pulses.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.

Decomposition:
- Package debounce_pkg holds:
  - repeat FSM state typedef (IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2);
  - width helper constants derived with $clog2 from the parameters.
- Sub-module debounce_repeat_ch implements one channel (synchroniser, debounce counter, repeat FSM). The top generates N_CH instances and concatenates their outputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_CH=3):
- Bounce: raw_in[0] toggles every 2 cycles for 20 cycles, then holds 1 → level[0] rises 6 cycles after the last edge; exactly one press[0] pulse; no release.
- Glitch: raw_in[1] high for 3 cycles, then low → level[1], press[1] and release[1] stay 0 throughout.
- Auto-repeat: rep_en[0]=1, raw_in[0] held 40 cycles → press at t0, t0+10, t0+13, t0+16…. After raw drops, exactly one release 6 cycles later and no further press pulses.
- Repeat disabled: rep_en[2]=0, hold 40 cycles → exactly one press[2]. Raising rep_en[2] at t0+20 → next press at t0+30.
- Reset mid-repeat: assert reset in REPEAT state → level, press and release all 0 the next cycle. With raw still high after release of reset, press reappears 6 cycles later.
- Simultaneous: all three raw_in rise on the same cycle → press=3'b111 for one cycle, with no cross-channel interference.
